// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage core: opcodes, the ID/EX payload struct
// and the flush-pending state encoding.
package cpu_pkg;

    localparam int CPU_XLEN = 32;
    localparam int CPU_RW   = 5;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_OPIMM = 7'b0010011;
    localparam logic [6:0] OP_OP    = 7'b0110011;

    typedef enum logic {
        FLUSH_IDLE,
        FLUSH_PENDING
    } flush_state_t;

    typedef struct packed {
        logic [CPU_XLEN-1:0] pc;
        logic [CPU_XLEN-1:0] rs1_data;
        logic [CPU_XLEN-1:0] rs2_data;
        logic [CPU_XLEN-1:0] imm;
        logic [CPU_RW-1:0]   rd;
        logic [6:0]          opcode;
        logic [2:0]          funct3;
        logic                is_load;
        logic                reg_write;
    } id_ex_t;

    // A bubble only has to neutralise the control fields; data may stay stale.
    function automatic id_ex_t make_bubble(input id_ex_t e);
        id_ex_t b;
        b           = e;
        b.rd        = '0;
        b.opcode    = '0;
        b.is_load   = 1'b0;
        b.reg_write = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/stage_id_ex_reg_sat_counter.sv
// Saturating up-counter used for the ID/EX bubble and flush statistics.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/stage_id_ex_reg.sv
// ID/EX pipeline register: captures the decoded instruction, inserts bubbles on
// stall/flush, freezes under EX back-pressure and remembers a flush seen while frozen.
import cpu_pkg::*;

module stage_id_ex_reg #(
    parameter int XLEN    = CPU_XLEN,
    parameter int REG_NUM = 32,
    parameter int CNT_W   = 16,
    localparam int RW     = $clog2(REG_NUM)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [RW-1:0]    id_rd,
    input  logic [6:0]       id_opcode,
    input  logic [2:0]       id_funct3,
    input  logic             id_is_load,
    input  logic             id_reg_write,
    input  logic             stall,
    input  logic             flush,
    input  logic             ex_hold,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [RW-1:0]    ex_rd,
    output logic [6:0]       ex_opcode,
    output logic [2:0]       ex_funct3,
    output logic             ex_is_load,
    output logic             ex_reg_write,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    id_ex_t       ex_q;
    logic         valid_q;
    flush_state_t state;
    logic         flush_path;
    logic         flush_inc;
    logic         bubble_inc;
    logic         rd_nonzero;

    assign flush_path = flush || (state == FLUSH_PENDING);
    assign flush_inc  = !ex_hold && flush_path && id_valid;
    assign bubble_inc = !ex_hold && !flush_path && stall;
    assign rd_nonzero = (id_rd != '0);

    // Writes to x0 are dropped here so the stall logic never waits on them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= '0;
            valid_q <= 1'b0;
            state   <= FLUSH_IDLE;
        end else if (ex_hold) begin
            if (flush) begin
                state <= FLUSH_PENDING;
            end
        end else if (flush_path) begin
            ex_q    <= make_bubble(ex_q);
            valid_q <= 1'b0;
            state   <= FLUSH_IDLE;
        end else if (stall) begin
            ex_q    <= make_bubble(ex_q);
            valid_q <= 1'b0;
        end else begin
            ex_q.pc        <= id_pc;
            ex_q.rs1_data  <= id_rs1_data;
            ex_q.rs2_data  <= id_rs2_data;
            ex_q.imm       <= id_imm;
            ex_q.rd        <= id_rd;
            ex_q.opcode    <= id_opcode;
            ex_q.funct3    <= id_funct3;
            ex_q.is_load   <= id_valid && id_is_load && rd_nonzero;
            ex_q.reg_write <= id_valid && id_reg_write && rd_nonzero;
            valid_q        <= id_valid;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_pc        = ex_q.pc;
    assign ex_rs1_data  = ex_q.rs1_data;
    assign ex_rs2_data  = ex_q.rs2_data;
    assign ex_imm       = ex_q.imm;
    assign ex_rd        = ex_q.rd;
    assign ex_opcode    = ex_q.opcode;
    assign ex_funct3    = ex_q.funct3;
    assign ex_is_load   = ex_q.is_load;
    assign ex_reg_write = ex_q.reg_write;

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bubble_inc),
        .count (bubble_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_stage_id_ex_reg.sv
// Self-checking bench for stage_id_ex_reg: vector table plus hand sequences,
// with expected results queued at drive time and popped after each edge.
module tb_stage_id_ex_reg;
    import cpu_pkg::*;

    localparam int XLEN  = 32;
    localparam int RW    = 5;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             id_valid;
    logic [XLEN-1:0]  id_pc;
    logic [XLEN-1:0]  id_rs1_data;
    logic [XLEN-1:0]  id_rs2_data;
    logic [XLEN-1:0]  id_imm;
    logic [RW-1:0]    id_rd;
    logic [6:0]       id_opcode;
    logic [2:0]       id_funct3;
    logic             id_is_load;
    logic             id_reg_write;
    logic             stall;
    logic             flush;
    logic             ex_hold;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_rs1_data;
    logic [XLEN-1:0]  ex_rs2_data;
    logic [XLEN-1:0]  ex_imm;
    logic [RW-1:0]    ex_rd;
    logic [6:0]       ex_opcode;
    logic [2:0]       ex_funct3;
    logic             ex_is_load;
    logic             ex_reg_write;
    logic [CNT_W-1:0] bubble_cnt;
    logic [CNT_W-1:0] flush_cnt;

    stage_id_ex_reg #(.XLEN(XLEN), .REG_NUM(32), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_pc        (id_pc),
        .id_rs1_data  (id_rs1_data),
        .id_rs2_data  (id_rs2_data),
        .id_imm       (id_imm),
        .id_rd        (id_rd),
        .id_opcode    (id_opcode),
        .id_funct3    (id_funct3),
        .id_is_load   (id_is_load),
        .id_reg_write (id_reg_write),
        .stall        (stall),
        .flush        (flush),
        .ex_hold      (ex_hold),
        .ex_valid     (ex_valid),
        .ex_pc        (ex_pc),
        .ex_rs1_data  (ex_rs1_data),
        .ex_rs2_data  (ex_rs2_data),
        .ex_imm       (ex_imm),
        .ex_rd        (ex_rd),
        .ex_opcode    (ex_opcode),
        .ex_funct3    (ex_funct3),
        .ex_is_load   (ex_is_load),
        .ex_reg_write (ex_reg_write),
        .bubble_cnt   (bubble_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ev;
        logic [31:0] epc;
        logic [4:0]  erd;
        logic [6:0]  eop;
        logic        eld;
        logic        erw;
        int          eb;
        int          ef;
        logic        chk;
    } exp_t;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [6:0]  op;
        logic        ld;
        logic        rw;
        logic        st;
        logic        fl;
        logic        hd;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[21];
    int   total = 0;
    int   bad   = 0;

    function automatic exp_t mkExp(logic ev, logic [31:0] epc, logic [4:0] erd, logic [6:0] eop,
                                   logic eld, logic erw, int eb, int ef, logic chk);
        exp_t e;
        e.ev = ev; e.epc = epc; e.erd = erd; e.eop = eop;
        e.eld = eld; e.erw = erw; e.eb = eb; e.ef = ef; e.chk = chk;
        return e;
    endfunction

    function automatic exp_t bub(int eb, int ef);
        return mkExp(1'b0, 32'h0, 5'd0, 7'd0, 1'b0, 1'b0, eb, ef, 1'b0);
    endfunction

    function automatic vec_t mkVec(logic v, logic [31:0] pc, logic [4:0] rd, logic [6:0] op,
                                   logic ld, logic rw, logic st, logic fl, logic hd, exp_t e);
        vec_t t;
        t.v = v; t.pc = pc; t.rd = rd; t.op = op; t.ld = ld; t.rw = rw;
        t.st = st; t.fl = fl; t.hd = hd; t.e = e;
        return t;
    endfunction

    function automatic int sat(int x);
        return (x > 15) ? 15 : x;
    endfunction

    task automatic cmpVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t t);
        id_valid     = t.v;
        id_pc        = t.pc;
        id_rs1_data  = t.pc ^ 32'hA5A5_0000;
        id_rs2_data  = t.pc + 32'h1000;
        id_imm       = ~t.pc;
        id_funct3    = t.pc[4:2];
        id_rd        = t.rd;
        id_opcode    = t.op;
        id_is_load   = t.ld;
        id_reg_write = t.rw;
        stall        = t.st;
        flush        = t.fl;
        ex_hold      = t.hd;
        sb.push_back(t.e);
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL %s.scoreboard actual=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            cmpVal({tag, ".valid"},     {31'b0, ex_valid},     {31'b0, e.ev});
            cmpVal({tag, ".rd"},        {27'b0, ex_rd},        {27'b0, e.erd});
            cmpVal({tag, ".opcode"},    {25'b0, ex_opcode},    {25'b0, e.eop});
            cmpVal({tag, ".is_load"},   {31'b0, ex_is_load},   {31'b0, e.eld});
            cmpVal({tag, ".reg_write"}, {31'b0, ex_reg_write}, {31'b0, e.erw});
            cmpVal({tag, ".bubble_cnt"}, {28'b0, bubble_cnt},  e.eb);
            cmpVal({tag, ".flush_cnt"},  {28'b0, flush_cnt},   e.ef);
            if (e.chk) begin
                cmpVal({tag, ".pc"},     ex_pc,       e.epc);
                cmpVal({tag, ".rs1"},    ex_rs1_data, e.epc ^ 32'hA5A5_0000);
                cmpVal({tag, ".rs2"},    ex_rs2_data, e.epc + 32'h1000);
                cmpVal({tag, ".imm"},    ex_imm,      ~e.epc);
                cmpVal({tag, ".funct3"}, {29'b0, ex_funct3}, {29'b0, e.epc[4:2]});
            end
        end
    endtask

    task automatic runVec(input vec_t t, input string tag);
        applyStimulus(t);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic checkZero(input string tag);
        cmpVal({tag, ".valid"},      {31'b0, ex_valid},     32'h0);
        cmpVal({tag, ".pc"},         ex_pc,                 32'h0);
        cmpVal({tag, ".rs1"},        ex_rs1_data,           32'h0);
        cmpVal({tag, ".imm"},        ex_imm,                32'h0);
        cmpVal({tag, ".rd"},         {27'b0, ex_rd},        32'h0);
        cmpVal({tag, ".opcode"},     {25'b0, ex_opcode},    32'h0);
        cmpVal({tag, ".is_load"},    {31'b0, ex_is_load},   32'h0);
        cmpVal({tag, ".reg_write"},  {31'b0, ex_reg_write}, 32'h0);
        cmpVal({tag, ".bubble_cnt"}, {28'b0, bubble_cnt},   32'h0);
        cmpVal({tag, ".flush_cnt"},  {28'b0, flush_cnt},    32'h0);
    endtask

    initial begin
        // v, pc, rd, op, ld, rw, stall, flush, hold, expected
        vecs[0]  = mkVec(1, 32'h100, 5, OP_LOAD,  1, 1, 0, 0, 0, mkExp(1, 32'h100, 5, OP_LOAD, 1, 1, 0, 0, 1));
        vecs[1]  = mkVec(1, 32'h104, 0, OP_LOAD,  1, 1, 0, 0, 0, mkExp(1, 32'h104, 0, OP_LOAD, 0, 0, 0, 0, 1));
        vecs[2]  = mkVec(0, 32'h108, 7, OP_OP,    0, 1, 0, 0, 0, mkExp(0, 32'h108, 7, OP_OP, 0, 0, 0, 0, 1));
        vecs[3]  = mkVec(1, 32'h10C, 3, OP_OP,    0, 1, 0, 0, 0, mkExp(1, 32'h10C, 3, OP_OP, 0, 1, 0, 0, 1));
        vecs[4]  = mkVec(1, 32'h110, 9, OP_LOAD,  1, 1, 1, 0, 0, bub(1, 0));
        vecs[5]  = mkVec(1, 32'h110, 9, OP_LOAD,  1, 1, 1, 0, 0, bub(2, 0));
        vecs[6]  = mkVec(1, 32'h110, 9, OP_LOAD,  1, 1, 1, 0, 0, bub(3, 0));
        vecs[7]  = mkVec(1, 32'h114, 9, OP_LOAD,  1, 1, 0, 0, 0, mkExp(1, 32'h114, 9, OP_LOAD, 1, 1, 3, 0, 1));
        vecs[8]  = mkVec(1, 32'h118, 4, OP_OPIMM, 0, 1, 0, 1, 0, bub(3, 1));
        vecs[9]  = mkVec(0, 32'h118, 4, OP_OPIMM, 0, 1, 0, 1, 0, bub(3, 1));
        vecs[10] = mkVec(1, 32'h118, 4, OP_OPIMM, 0, 1, 1, 1, 0, bub(3, 2));
        vecs[11] = mkVec(1, 32'h11C, 6, OP_OPIMM, 0, 1, 0, 0, 0, mkExp(1, 32'h11C, 6, OP_OPIMM, 0, 1, 3, 2, 1));
        vecs[12] = mkVec(1, 32'h120, 8, OP_OP,    0, 1, 0, 1, 1, mkExp(1, 32'h11C, 6, OP_OPIMM, 0, 1, 3, 2, 1));
        vecs[13] = mkVec(1, 32'h124, 8, OP_OP,    0, 1, 0, 0, 1, mkExp(1, 32'h11C, 6, OP_OPIMM, 0, 1, 3, 2, 1));
        vecs[14] = mkVec(1, 32'h124, 8, OP_OP,    0, 1, 1, 0, 1, mkExp(1, 32'h11C, 6, OP_OPIMM, 0, 1, 3, 2, 1));
        vecs[15] = mkVec(1, 32'h128, 2, OP_OP,    0, 1, 0, 0, 0, bub(3, 3));
        vecs[16] = mkVec(1, 32'h12C, 2, OP_OP,    0, 1, 0, 0, 0, mkExp(1, 32'h12C, 2, OP_OP, 0, 1, 3, 3, 1));
        vecs[17] = mkVec(1, 32'h130, 5, OP_LOAD,  1, 1, 0, 1, 1, mkExp(1, 32'h12C, 2, OP_OP, 0, 1, 3, 3, 1));
        vecs[18] = mkVec(1, 32'h130, 5, OP_LOAD,  1, 1, 0, 1, 1, mkExp(1, 32'h12C, 2, OP_OP, 0, 1, 3, 3, 1));
        vecs[19] = mkVec(0, 32'h134, 5, OP_LOAD,  1, 1, 0, 0, 0, bub(3, 3));
        vecs[20] = mkVec(1, 32'h138, 1, OP_LOAD,  1, 0, 0, 0, 0, mkExp(1, 32'h138, 1, OP_LOAD, 1, 0, 3, 3, 1));

        rst_n        = 1'b0;
        id_valid     = 1'b1;
        id_pc        = $urandom;
        id_rs1_data  = $urandom;
        id_rs2_data  = $urandom;
        id_imm       = $urandom;
        id_rd        = 5'($urandom_range(1, 31));
        id_opcode    = OP_LOAD;
        id_funct3    = 3'($urandom_range(0, 7));
        id_is_load   = 1'b1;
        id_reg_write = 1'b1;
        stall        = 1'b0;
        flush        = 1'b0;
        ex_hold      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkZero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            runVec(vecs[i], $sformatf("vec%0d", i));
        end

        // bubble counter must pin at all-ones
        for (int i = 1; i <= 20; i++) begin
            runVec(mkVec(1, 32'h140, 9, OP_LOAD, 1, 1, 1, 0, 0, bub(sat(3 + i), 3)),
                   $sformatf("satb%0d", i));
        end
        runVec(mkVec(1, 32'h144, 9, OP_LOAD, 1, 1, 1, 1, 0, bub(15, 4)), "stall_flush");
        for (int i = 1; i <= 14; i++) begin
            runVec(mkVec(1, 32'h148, 9, OP_LOAD, 1, 1, 0, 1, 0, bub(15, sat(4 + i))),
                   $sformatf("satf%0d", i));
        end

        // reset in the middle of a held flush must drop the pending bubble
        runVec(mkVec(1, 32'h150, 4, OP_OP, 0, 1, 0, 1, 1, bub(15, 15)), "hold_flush");
        #2;
        rst_n = 1'b0;
        #1;
        checkZero("async_reset");
        @(posedge clk);
        #1;
        checkZero("reset_held");
        rst_n = 1'b1;
        runVec(mkVec(1, 32'h200, 10, OP_OP, 0, 1, 0, 0, 0, mkExp(1, 32'h200, 10, OP_OP, 0, 1, 0, 0, 1)),
               "post_reset");

        cmpVal("scoreboard_drained", sb.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
